// File: rtl/drive_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// drive_cmd_arbiter
//
// Accepts drive commands from NUM_SRC valid/ready sources, grants the
// lowest-index valid source each cycle, decodes ASCII 'a'..'e' into a 3-bit
// motor command and runs a deadman timer that forces brake when commands stop.
// A telemetry byte {prox_status[3:0], motor_cmd[2:0], 1'b1} is offered on a
// valid/ready port on every periodic tick and on every motor command change.
//
// Optional feature (compile-time macro DRIVE_CMD_SRC_LOCK_EN):
//   defined   - the source that issued the active command owns the drive; other
//               sources are still handshaken but their commands are dropped
//               until the deadman releases the lock.
//   undefined - plain fixed priority on every command.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   src_valid     per-source command valid
//   src_ready     per-source ready, combinational one-hot grant
//   src_code      packed source codes, source i at [i*CODE_W +: CODE_W]
//   prox_in       raw proximity reading
//   motor_cmd     current motor command (001 fwd, 010 left, 011 brake,
//                 100 right, 101 back)
//   cmd_src       index of the source that issued the current command
//   cmd_active    a command is in force and has not timed out
//   timeout_flag  deadman has fired since the last valid command
//   tx_valid      telemetry byte valid
//   tx_ready      telemetry sink ready
//   tx_byte       telemetry byte, stable while tx_valid is high
// -----------------------------------------------------------------------------
module drive_cmd_arbiter #(
  parameter int NUM_SRC        = 2,
  parameter int CODE_W         = 8,
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter int TELEM_PERIOD   = 5_000_000,
  parameter int PROX_W         = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_SRC-1:0]                           src_valid,
  output logic [NUM_SRC-1:0]                           src_ready,
  input  logic [NUM_SRC*CODE_W-1:0]                    src_code,
  input  logic [PROX_W-1:0]                            prox_in,
  output logic [2:0]                                   motor_cmd,
  output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] cmd_src,
  output logic                                         cmd_active,
  output logic                                         timeout_flag,
  output logic                                         tx_valid,
  input  logic                                         tx_ready,
  output logic [7:0]                                   tx_byte
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int TP_W  = $clog2(TELEM_PERIOD);

  localparam logic [2:0] CMD_BRAKE = 3'b011;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // Fixed-priority grant: the lowest-index valid source wins.
  // ---------------------------------------------------------------------------
  logic             any_grant;
  logic [SRC_W-1:0] sel_idx;
  logic [CODE_W-1:0] sel_code;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    src_ready = '0;
    any_grant = 1'b0;
    sel_idx   = '0;
    sel_code  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && !any_grant) begin
        any_grant    = 1'b1;
        src_ready[i] = 1'b1;
        sel_idx      = SRC_W'(i);
        sel_code     = src_code[i*CODE_W +: CODE_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Code decode. Unknown codes are still handshaken but change nothing.
  // ---------------------------------------------------------------------------
  logic       dec_ok;
  logic [2:0] dec_cmd;

  always_comb begin
    dec_ok  = 1'b1;
    dec_cmd = CMD_BRAKE;
    case (sel_code[7:0])
      8'h61:   dec_cmd = 3'b001;
      8'h62:   dec_cmd = 3'b010;
      8'h63:   dec_cmd = 3'b011;
      8'h64:   dec_cmd = 3'b100;
      8'h65:   dec_cmd = 3'b101;
      default: dec_ok  = 1'b0;
    endcase
  end

  // Ownership check: while a command is active only its issuer may replace it.
  logic lock_ok;
`ifdef DRIVE_CMD_SRC_LOCK_EN
  assign lock_ok = !cmd_active || (sel_idx == cmd_src);
`else
  assign lock_ok = 1'b1;
`endif

  logic cmd_load;
  assign cmd_load = any_grant && dec_ok && lock_ok;

  // ---------------------------------------------------------------------------
  // Command state and deadman timer. An accept in the timeout cycle wins.
  // ---------------------------------------------------------------------------
  logic [TO_W-1:0]  dead_cnt, dead_next;
  logic [2:0]       motor_cmd_next;
  logic [SRC_W-1:0] cmd_src_next;
  logic             active_next, tflag_next;
  logic             timeout_hit;

  assign timeout_hit = cmd_active && (dead_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    motor_cmd_next = motor_cmd;
    cmd_src_next   = cmd_src;
    active_next    = cmd_active;
    tflag_next     = timeout_flag;
    dead_next      = dead_cnt;
    if (cmd_load) begin
      motor_cmd_next = dec_cmd;
      cmd_src_next   = sel_idx;
      active_next    = 1'b1;
      tflag_next     = 1'b0;
      dead_next      = '0;
    end else if (timeout_hit) begin
      motor_cmd_next = CMD_BRAKE;
      active_next    = 1'b0;
      tflag_next     = 1'b1;
      dead_next      = '0;
    end else if (cmd_active) begin
      dead_next      = dead_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      motor_cmd    <= '0;
      cmd_src      <= '0;
      cmd_active   <= 1'b0;
      timeout_flag <= 1'b0;
      dead_cnt     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      motor_cmd    <= motor_cmd_next;
      cmd_src      <= cmd_src_next;
      cmd_active   <= active_next;
      timeout_flag <= tflag_next;
      dead_cnt     <= dead_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Telemetry events: free-running period tick, or a motor command change.
  // The event is registered, so a frame starts one edge after the event edge.
  // ---------------------------------------------------------------------------
  logic [TP_W-1:0] per_cnt;
  logic            per_wrap;
  logic            event_q;

  assign per_wrap = (per_cnt == TP_W'(TELEM_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      event_q <= 1'b0;
    end else begin
      per_cnt <= per_wrap ? '0 : per_cnt + 1'b1;
      event_q <= (motor_cmd_next != motor_cmd) || per_wrap;
    end
  end

  // Proximity nibble, compared at full input width before slicing.
  logic [3:0] prox_status;

  always_comb begin
    if (prox_in >= PROX_W'(63))     prox_status = 4'hF;
    else if (prox_in < PROX_W'(4))  prox_status = 4'h0;
    else                            prox_status = prox_in[5:2];
  end

  // ---------------------------------------------------------------------------
  // Telemetry FSM: state register / next-state / outputs.
  // Events while a frame is outstanding coalesce into one pending flag.
  // ---------------------------------------------------------------------------
  tx_state_t state, state_next;
  logic      pending;
  logic      launch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (event_q || pending) state_next = SEND;
      SEND:    if (tx_ready)           state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = (state == SEND);
    launch   = (state == IDLE) && (event_q || pending);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_byte <= 8'h00;
      pending <= 1'b0;
    end else if (launch) begin
      // Capture the command being written this edge so the byte is current.
      tx_byte <= {prox_status, motor_cmd_next, 1'b1};
      pending <= 1'b0;
    end else if (state == SEND && event_q) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_drive_cmd_arbiter
//
// Directed scenarios followed by randomized traffic against a behavioural
// reference. The reference tracks time stamps (edge of last accepted command)
// and pushes every expected telemetry byte into a queue; a monitor on the
// falling edge compares per-cycle state and pops the queue on each handshake.
// -----------------------------------------------------------------------------
module tb_drive_cmd_arbiter;

  localparam int NUM_SRC = 2;
  localparam int CODE_W  = 8;
  localparam int T_OUT   = 16;
  localparam int T_PER   = 50;
  localparam int PROX_W  = 8;
  localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*CODE_W-1:0] src_code;
  logic [PROX_W-1:0]         prox_in;
  logic [2:0]                motor_cmd;
  logic [SRC_W-1:0]          cmd_src;
  logic                      cmd_active;
  logic                      timeout_flag;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [7:0]                tx_byte;

  drive_cmd_arbiter #(
    .NUM_SRC        (NUM_SRC),
    .CODE_W         (CODE_W),
    .TIMEOUT_CYCLES (T_OUT),
    .TELEM_PERIOD   (T_PER),
    .PROX_W         (PROX_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_code     (src_code),
    .prox_in      (prox_in),
    .motor_cmd    (motor_cmd),
    .cmd_src      (cmd_src),
    .cmd_active   (cmd_active),
    .timeout_flag (timeout_flag),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_byte      (tx_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int        m_edge;
  logic [2:0] m_motor;
  int        m_src;
  bit        m_active, m_tflag;
  int        m_last;
  int        m_grant;
  bit        m_busy, m_pend, m_evt_prev;
  logic [7:0] exp_q[$];

  function automatic int prox_nib(input int p);
    if (p >= 63) return 15;
    if (p < 4)   return 0;
    return (p / 4) % 16;
  endfunction

  function automatic int grant_of(input logic [NUM_SRC-1:0] v);
    for (int i = 0; i < NUM_SRC; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [NUM_SRC-1:0] onehot_of(input int g);
    logic [NUM_SRC-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_edge = 0; m_motor = 3'b000; m_src = 0; m_active = 0; m_tflag = 0;
    m_last = 0; m_grant = -1; m_busy = 0; m_pend = 0; m_evt_prev = 0;
    exp_q.delete();
  endtask

  // Applies one clock edge using the inputs currently driven on the DUT.
  task automatic model_edge();
    logic [7:0] code;
    logic [2:0] old;
    bit is_cmd, evt_now;
    m_edge++;
    old     = m_motor;
    m_grant = grant_of(src_valid);
    is_cmd  = 0;
    if (m_grant >= 0) begin
      code   = src_code[m_grant*CODE_W +: 8];
      is_cmd = (code >= 8'h61) && (code <= 8'h65);
`ifdef DRIVE_CMD_SRC_LOCK_EN
      if (m_active && m_grant != m_src) is_cmd = 0;
`endif
    end
    if (is_cmd) begin
      m_motor = 3'(code - 8'h60); m_src = m_grant;
      m_active = 1; m_tflag = 0; m_last = m_edge;
    end else if (m_active && (m_edge - m_last == T_OUT)) begin
      m_motor = 3'b011; m_active = 0; m_tflag = 1;
    end
    evt_now = (m_motor != old) || (m_edge % T_PER == 0);
    if (m_busy) begin
      if (m_evt_prev) m_pend = 1;
      if (tx_ready)   m_busy = 0;
    end else if (m_evt_prev || m_pend) begin
      m_busy = 1; m_pend = 0;
      exp_q.push_back({4'(prox_nib(int'(prox_in))), m_motor, 1'b1});
    end
    m_evt_prev = evt_now;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares on the falling edge, away from the active edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("src_ready",    src_ready,    onehot_of(grant_of(src_valid)));
      check("motor_cmd",    motor_cmd,    m_motor);
      check("cmd_src",      cmd_src,      m_src);
      check("cmd_active",   cmd_active,   m_active);
      check("timeout_flag", timeout_flag, m_tflag);
      check("tx_valid",     tx_valid,     m_busy);
      if (tx_valid) begin
        check("tx_frame_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          check("tx_byte", tx_byte, exp_q[0]);
          if (tx_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (rst_n) model_edge();
    end
  endtask

  task automatic set_src(input int i, input bit v, input logic [7:0] c);
    src_valid[i] = v;
    src_code[i*CODE_W +: CODE_W] = CODE_W'(c);
  endtask

  task automatic idle_srcs();
    src_valid = '0;
  endtask

  function automatic logic [7:0] rand_code();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)  return 8'h61 + 8'($urandom_range(0, 4));
    if (r == 7) return 8'h7A;
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic logic [7:0] rand_prox();
    logic [7:0] tbl [9];
    tbl = '{8'h00, 8'h03, 8'h04, 8'h3E, 8'h3F, 8'h40, 8'hFF, 8'h20, 8'h24};
    if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 8)];
    return 8'($urandom_range(0, 255));
  endfunction

  // Granted sources pick fresh work; stalled sources hold valid and code.
  task automatic rand_inputs(input int act_pct, input int rdy_pct);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i == m_grant || !src_valid[i]) begin
        if ($urandom_range(0, 99) < act_pct) set_src(i, 1'b1, rand_code());
        else src_valid[i] = 1'b0;
      end
    end
    tx_ready = ($urandom_range(0, 99) < rdy_pct);
    if ($urandom_range(0, 7) == 0) prox_in = rand_prox();
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_srcs();
    tx_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_motor_cmd",    motor_cmd,    3'b000);
    check("rst_cmd_src",      cmd_src,      0);
    check("rst_cmd_active",   cmd_active,   1'b0);
    check("rst_timeout_flag", timeout_flag, 1'b0);
    check("rst_tx_valid",     tx_valid,     1'b0);
    check("rst_tx_byte",      tx_byte,      8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    src_valid = '0;
    src_code  = '0;
    prox_in   = '0;
    tx_ready  = 1'b0;
    model_reset();
    #12;
    apply_reset();
    mon_en = 1'b1;

    // First command from src0 with prox 0x20: frame byte 0x83.
    prox_in  = 8'h20;
    tx_ready = 1'b1;
    set_src(0, 1'b1, 8'h61);
    step();
    idle_srcs();
    step(4);

    // Simultaneous requests: src0 wins, src1 stalls and goes next.
    set_src(0, 1'b1, 8'h62);
    set_src(1, 1'b1, 8'h64);
    step();
    src_valid[0] = 1'b0;
    step();
    idle_srcs();
    step(4);

    // Silence after a command: deadman forces brake and reports it.
    set_src(0, 1'b1, 8'h61);
    step();
    idle_srcs();
    step(T_OUT + 6);

    // Invalid code is consumed without reloading the timer.
    set_src(1, 1'b1, 8'h65);
    step();
    idle_srcs();
    step(5);
    set_src(0, 1'b1, 8'h7A);
    step();
    idle_srcs();
    step(T_OUT);

    // Sink stalled across three changes, then released.
    tx_ready = 1'b0;
    set_src(0, 1'b1, 8'h61); step(); idle_srcs(); step(2);
    set_src(0, 1'b1, 8'h62); step(); idle_srcs(); step(2);
    set_src(1, 1'b1, 8'h64); step(); idle_srcs(); step(3);
    tx_ready = 1'b1;
    step(8);

    // Proximity boundaries.
    prox_in = 8'hFF; set_src(0, 1'b1, 8'h65); step(); idle_srcs(); step(4);
    prox_in = 8'h03; set_src(0, 1'b1, 8'h61); step(); idle_srcs(); step(4);
    prox_in = 8'h24; set_src(0, 1'b1, 8'h62); step(); idle_srcs(); step(4);
    prox_in = 8'h3F; set_src(1, 1'b1, 8'h63); step(); idle_srcs(); step(4);

    // Randomized traffic across activity/backpressure mixes.
    for (int ph = 0; ph < 6; ph++) begin
      int act, rdy;
      act = (ph % 3 == 0) ? 60 : (ph % 3 == 1) ? 15 : 3;
      rdy = (ph < 3) ? 80 : 25;
      for (int c = 0; c < 400; c++) begin
        rand_inputs(act, rdy);
        step();
      end
    end

    // Reset in the middle of a frame drops it.
    tx_ready = 1'b0;
    set_src(0, 1'b1, 8'h64);
    step();
    idle_srcs();
    step(2);
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      rand_inputs(20, 60);
      step();
    end

    idle_srcs();
    tx_ready = 1'b1;
    step(T_OUT + 8);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/drive_cmd_arbiter.md
Name: drive_cmd_arbiter

Overview:
Parametrised successor to the robot's single-path IR/UART command decode. It accepts drive commands from NUM_SRC independent sources over valid/ready, arbitrates between them by fixed priority, and maps each code to a 3-bit motor command. A deadman timer forces brake when commands stop arriving. A telemetry byte (proximity status plus motor command) is produced on a periodic tick or on any command change, using the same valid/ready handshake as uart_tx.

Parameters:
- NUM_SRC, 2, number of command sources; index 0 has the highest priority.
- CODE_W, 8, width of each source code; only bits [7:0] are decoded.
- TIMEOUT_CYCLES, 25_000_000, deadman period in clk cycles (0.5 s at 50 MHz); must be at least 2.
- TELEM_PERIOD, 5_000_000, periodic telemetry interval in clk cycles; must be at least 2.
- PROX_W, 8, width of the raw proximity input; must be at least 6.

Ports:
- clk, in, 1, system clock (50 MHz).
- rst_n, in, 1, asynchronous active-low reset.
- src_valid, in, NUM_SRC, per-source command valid.
- src_ready, out, NUM_SRC, per-source ready; combinational one-hot grant.
- src_code, in, NUM_SRC*CODE_W, packed codes; source i occupies [i*CODE_W +: CODE_W].
- prox_in, in, PROX_W, raw proximity reading.
- motor_cmd, out, 3, current motor command.
- cmd_src, out, max(1,$clog2(NUM_SRC)), index of the source that issued the current command.
- cmd_active, out, 1, a command has been accepted and has not timed out.
- timeout_flag, out, 1, deadman has fired.
- tx_valid, out, 1, telemetry byte valid.
- tx_ready, in, 1, telemetry sink ready.
- tx_byte, out, 8, telemetry byte.

Behaviour:
- Reset values: motor_cmd=000, cmd_src=0, cmd_active=0, timeout_flag=0, tx_valid=0, tx_byte=0x00. All counters are cleared and the pending flag is cleared. A reset mid-frame drops the frame immediately.
- Grant: src_ready[i]=1 only when src_valid[i]=1 and no j<i has src_valid[j]=1. At most one ready bit is high per cycle. Losing sources stall and hold their code.
- Accept: a transfer happens when valid&ready. Decode of code[7:0]:
  - 0x61 -> 001 fwd
  - 0x62 -> 010 left
  - 0x63 -> 011 brake
  - 0x64 -> 100 right
  - 0x65 -> 101 back
  - Any other value is consumed (ready still given) and ignored: no state change, no timer reload.
- Valid decode, cycle N: motor_cmd, cmd_src, cmd_active=1 and timeout_flag=0 update at edge N+1. The deadman counter reloads to 0. A repeated identical command reloads the timer but does not count as a change.
- Deadman: the counter runs only while cmd_active=1. When it reaches TIMEOUT_CYCLES-1, the next edge sets motor_cmd=011, cmd_active=0, timeout_flag=1. timeout_flag holds until the next valid command. If a timeout and an accept occur in the same cycle, the accept wins.
- prox_status (4 bits):
  - 15 if prox_in>=63
  - 0 if prox_in<4
  - otherwise prox_in[5:2]
  - Computed at full PROX_W width, with no truncation before the compare.
- Telemetry events: the period counter wraps at TELEM_PERIOD-1 and produces a tick. A change of motor_cmd, including one caused by timeout, is also an event.
- FSM: IDLE -> SEND on an event, or on pending=1.
  - On entering SEND: tx_byte={prox_status, motor_cmd_next, 1'b1} is captured at that same edge, so the byte reflects the new command. tx_valid=1.
  - tx_byte is held stable while in SEND.
  - SEND -> IDLE on tx_valid&tx_ready.
  - Any events during SEND, including one in the handshake cycle, set a single pending flag (coalesced). Pending is cleared when its frame launches.
  - Latency: event at edge N gives tx_valid=1 after edge N+1. Minimum gap between frames is 1 IDLE cycle.
- The period counter free-runs and is not reset by change events.

Optional Feature:
- Macro: DRIVE_CMD_SRC_LOCK_EN.
- Defined: after a valid command from source k, commands from any source i!=k are accepted (ready given) but discarded until cmd_active falls to 0 (timeout). Source k always retains access. Reset clears the lock.
- Undefined: pure fixed priority on every command, and cmd_src may change on each accept.

Test Plan:
- Reset, then src0 sends 0x61 -> after 1 cycle motor_cmd=001, cmd_src=0, cmd_active=1. Next cycle tx_valid=1 and tx_byte={prox_status,001,1}; with prox_in=0x20, tx_byte=0x83.
- src0 and src1 valid in the same cycle (0x62/0x64) -> src_ready=01, motor_cmd=010. Next cycle src_ready=10, motor_cmd=100, cmd_src=1.
- With TIMEOUT_CYCLES=16, one 0x61 then silence -> 16 cycles later motor_cmd=011, timeout_flag=1, and a telemetry frame reports 011.
- Invalid code 0x7A -> src_ready=1, no state change, no frame, timer not reloaded.
- Hold tx_ready=0 across 3 command changes -> tx_byte stays stable. After tx_ready=1, exactly one more frame is sent, carrying the latest command.
- prox_in=0xFF -> nibble 15; prox_in=0x03 -> nibble 0; prox_in=0x24 -> nibble 9. With DRIVE_CMD_SRC_LOCK_EN, src0 is ignored while src1 holds the lock.
